// File: rtl/debounce_pkg.sv
`default_nettype none
//============================================================================
// Module      : debounce_pkg
// Description : Shared helpers and default filter lengths for the
//               debounce_bank slice.
// Revision    : 1.0 - initial release
//============================================================================
package debounce_pkg;

    // Typical filter lengths, in qualifying samples minus one.
    localparam int KEYPAD_COUNT_MAX = 255;
    localparam int BUTTON_COUNT_MAX = 65535;

    // Width of a counter that must hold 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
//============================================================================
// Module      : debounce_chan
// Description : One debounce channel. A candidate level must be seen for
//               COUNT_MAX+1 consecutive qualifying samples before it is
//               committed to o_dout; commits that change the level raise a
//               single-cycle rise or fall pulse.
// Build option: DEBOUNCE_BANK_SYNC_EN - insert a two-flop synchroniser
//               (reset to RESET_BIT) in front of the filter.
// Revision    : 1.0 - initial release
//============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   COUNT_MAX = KEYPAD_COUNT_MAX,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_din,
    output logic o_dout,
    output logic o_rise,
    output logic o_fall,
    output logic o_event_nxt
);

    // Counter only ever needs to reach COUNT_MAX, where it saturates.
    localparam int CNT_W = cnt_width(COUNT_MAX);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(COUNT_MAX);

    logic             w_sample;
    logic             r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;

    logic             w_mismatch;
    logic             w_saturated;
    logic             w_commit;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

`ifdef DEBOUNCE_BANK_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser for an input that may be asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= RESET_BIT;
            r_sync2 <= RESET_BIT;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    // Caller guarantees i_din is already synchronous to clk.
    assign w_sample = i_din;
`endif

    // Qualification decode: a mismatch always wins, even without a tick.
    always_comb begin
        w_mismatch  = (w_sample != r_cand);
        w_saturated = (r_cnt == c_cnt_max);
        w_commit    = !w_mismatch && i_tick && w_saturated;
        // Re-committing the level already on o_dout is silent.
        w_rise_nxt  = w_commit &&  r_cand && !r_dout;
        w_fall_nxt  = w_commit && !r_cand &&  r_dout;
    end

    // Candidate level and its run-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= RESET_BIT;
            r_cnt  <= '0;
        end else if (w_mismatch) begin
            // Any disagreement restarts the interval from scratch.
            r_cand <= w_sample;
            r_cnt  <= '0;
        end else if (i_tick && !w_saturated) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Committed level plus its one-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= RESET_BIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            if (w_commit) begin
                r_dout <= r_cand;
            end
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    assign o_dout      = r_dout;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    // Exposed so the bank can register its summary flag alongside the pulses.
    assign o_event_nxt = w_rise_nxt | w_fall_nxt;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
//============================================================================
// Module      : debounce_bank
// Description : NUM_CH independent debounce channels with a shared sample
//               tick, per-channel reset level, rise/fall event pulses and a
//               registered "any channel changed" flag.
// Build option: DEBOUNCE_BANK_SYNC_EN - every channel gets a two-flop
//               input synchroniser (adds two clocks of latency).
// Revision    : 1.0 - initial release
//============================================================================
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                COUNT_MAX   = KEYPAD_COUNT_MAX,
    parameter logic [NUM_CH-1:0] RESET_LEVEL = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              changed
);

    logic [NUM_CH-1:0] w_event_nxt;
    logic              r_changed;

    // One filter per input pin; channels share nothing but clk/rst/tick.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        debounce_chan #(
            .COUNT_MAX (COUNT_MAX),
            .RESET_BIT (RESET_LEVEL[gi])
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_tick      (tick),
            .i_din       (din[gi]),
            .o_dout      (dout[gi]),
            .o_rise      (rise[gi]),
            .o_fall      (fall[gi]),
            .o_event_nxt (w_event_nxt[gi])
        );
    end

    // Summary flag registered from the same next-state terms as the pulses,
    // so it lines up with rise/fall cycle for cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_event_nxt;
        end
    end

    assign changed = r_changed;

endmodule : debounce_bank
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
//============================================================================
// Module      : tb_debounce_bank
// Description : Self-checking bench for debounce_bank (NUM_CH=4,
//               COUNT_MAX=4, RESET_LEVEL=4'b0101). Follows the
//               DEBOUNCE_BANK_SYNC_EN build option of the design.
// Revision    : 1.0 - initial release
//============================================================================
module tb_debounce_bank;

    localparam int         NUM_CH    = 4;
    localparam int         COUNT_MAX = 4;
    localparam logic [3:0] RL        = 4'b0101;
`ifdef DEBOUNCE_BANK_SYNC_EN
    localparam int         SYNC_LAT  = 2;
`else
    localparam int         SYNC_LAT  = 0;
`endif
    // Edges from the first edge that sees new din (E0) to the commit edge.
    localparam int         LAT       = COUNT_MAX + 1 + SYNC_LAT;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick  = 1'b1;
    logic [3:0] din   = RL;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    debounce_bank #(
        .NUM_CH      (NUM_CH),
        .COUNT_MAX   (COUNT_MAX),
        .RESET_LEVEL (RL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .din     (din),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a level commits on a ticked edge once the number of
    // ticked edges since the level was first seen reaches COUNT_MAX+1.
    // Tracked as a running tick total and the total at each level start.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]               cur;
        logic [3:0]               dout;
        logic [3:0]               rise;
        logic [3:0]               fall;
        logic [3:0]               d1;
        logic [3:0]               d2;
        logic [31:0]              ticks;
        logic [NUM_CH-1:0][31:0]  start;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.cur   = RL;
        r.dout  = RL;
        r.rise  = '0;
        r.fall  = '0;
        r.d1    = RL;
        r.d2    = RL;
        r.ticks = '0;
        r.start = '0;
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t p, input logic [3:0] d_in, input logic t_in);
        mstate_t    n;
        logic [3:0] s;
        n = p;
`ifdef DEBOUNCE_BANK_SYNC_EN
        s    = p.d2;
        n.d1 = d_in;
        n.d2 = p.d1;
`else
        s    = d_in;
`endif
        n.ticks = p.ticks + (t_in ? 32'd1 : 32'd0);
        n.rise  = '0;
        n.fall  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s[c] != p.cur[c]) begin
                n.cur[c]   = s[c];
                n.start[c] = n.ticks;
            end else if (t_in && (n.ticks - p.start[c]) >= 32'(COUNT_MAX + 1)) begin
                if (p.dout[c] != s[c]) begin
                    n.rise[c] = s[c];
                    n.fall[c] = ~s[c];
                end
                n.dout[c] = s[c];
            end
        end
        return n;
    endfunction

    initial begin
        m = model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m = model_reset();
            else        m = model_next(m, din, tick);
        end
    end

    // Continuous comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_checks++;
                if (dout !== m.dout) begin
                    n_fail++;
                    $display("FAIL model_dout t=%0t actual=%b expected=%b", $time, dout, m.dout);
                end
                n_checks++;
                if (rise !== m.rise) begin
                    n_fail++;
                    $display("FAIL model_rise t=%0t actual=%b expected=%b", $time, rise, m.rise);
                end
                n_checks++;
                if (fall !== m.fall) begin
                    n_fail++;
                    $display("FAIL model_fall t=%0t actual=%b expected=%b", $time, fall, m.fall);
                end
                n_checks++;
                if (changed !== |(m.rise | m.fall)) begin
                    n_fail++;
                    $display("FAIL model_changed t=%0t actual=%b expected=%b", $time, changed, |(m.rise | m.fall));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        din   = RL;
        tick  = 1'b1;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        mon_en = 1'b1;
        n_checks++;
        if (dout !== RL) begin
            n_fail++; $display("FAIL reset_dout actual=%b expected=%b", dout, RL);
        end
        n_checks++;
        if ({rise, fall, changed} !== 9'b0) begin
            n_fail++; $display("FAIL reset_pulses actual=%b/%b/%b expected=0/0/0", rise, fall, changed);
        end
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (dout !== RL || rise !== 4'b0 || fall !== 4'b0 || changed !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_quiet k=%0d actual=%b/%b/%b/%b expected=%b/0000/0000/0", k, dout, rise, fall, changed, RL);
            end
        end
        // Commit a different level, then reset in the middle of a new count.
        din = 4'b1010;
        repeat (LAT + 2) step();
        n_checks++;
        if (dout !== 4'b1010) begin
            n_fail++; $display("FAIL reset_precommit actual=%b expected=1010", dout);
        end
        din = 4'b0000;
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dout !== RL || {rise, fall, changed} !== 9'b0) begin
            n_fail++; $display("FAIL reset_midrun actual=%b/%b/%b/%b expected=%b/0000/0000/0", dout, rise, fall, changed, RL);
        end
        @(negedge clk);
        din   = RL;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (dout !== RL || {rise, fall, changed} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_midrun_release k=%0d actual=%b/%b/%b/%b expected=%b/0000/0000/0", k, dout, rise, fall, changed, RL);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_clean_edge();
        din = 4'b0000;
        repeat (LAT + 3) step();
        n_checks++;
        if (dout !== 4'b0000) begin
            n_fail++; $display("FAIL clean_settle actual=%b expected=0000", dout);
        end
        din[0] = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            step();
            n_checks++;
            if (rise[0] !== (k == LAT) || changed !== (k == LAT) || dout[0] !== (k >= LAT)) begin
                n_fail++;
                $display("FAIL clean_edge E%0d actual rise0=%b chg=%b dout0=%b expected rise0=%b chg=%b dout0=%b",
                         k, rise[0], changed, dout[0], (k == LAT), (k == LAT), (k >= LAT));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bounce();
        din[1] = 1'b1; step();
        din[1] = 1'b0; step();
        din[1] = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            step();
            n_checks++;
            if (dout[1] !== (k >= LAT) || rise[1] !== (k == LAT)) begin
                n_fail++;
                $display("FAIL bounce_commit E%0d actual dout1=%b rise1=%b expected dout1=%b rise1=%b",
                         k, dout[1], rise[1], (k >= LAT), (k == LAT));
            end
        end
        din[1] = 1'b0;
        repeat (LAT + 3) step();
        din[1] = 1'b1;
        repeat (COUNT_MAX) step();
        din[1] = 1'b0;
        for (int k = 0; k <= LAT + 4; k++) begin
            step();
            n_checks++;
            if (dout[1] !== 1'b0 || rise[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_reject k=%0d actual dout1=%b rise1=%b expected dout1=0 rise1=0", k, dout[1], rise[1]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tick_gating();
        int nt;
        int r_edge;
        bit exp_r;
        nt     = 0;
        din[2] = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            tick = (k % 3 == 2);
            step();
            if (k > SYNC_LAT && tick) nt++;
            exp_r = (k > SYNC_LAT) && tick && (nt == 5);
            n_checks++;
            if (rise[2] !== exp_r || dout[2] !== (nt >= 5)) begin
                n_fail++;
                $display("FAIL tick_gated k=%0d actual rise2=%b dout2=%b expected rise2=%b dout2=%b",
                         k, rise[2], dout[2], exp_r, (nt >= 5));
            end
        end
        tick   = 1'b1;
        din[2] = 1'b0;
        repeat (LAT + 3) step();
        // One-cycle low glitch on a non-tick cycle restarts the interval.
        nt     = 0;
        r_edge = 8 + SYNC_LAT;
        for (int k = 0; k <= 26; k++) begin
            tick   = (k % 3 == 2);
            din[2] = (k == 7) ? 1'b0 : 1'b1;
            step();
            if (k > r_edge && tick) nt++;
            exp_r = (k > r_edge) && tick && (nt == 5);
            n_checks++;
            if (rise[2] !== exp_r || dout[2] !== (nt >= 5)) begin
                n_fail++;
                $display("FAIL tick_glitch k=%0d actual rise2=%b dout2=%b expected rise2=%b dout2=%b",
                         k, rise[2], dout[2], exp_r, (nt >= 5));
            end
        end
        tick = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_simultaneous();
        din = 4'b0000;
        repeat (LAT + 3) step();
        din = 4'b1111;
        for (int k = 0; k <= LAT + 2; k++) begin
            step();
            n_checks++;
            if (rise !== ((k == LAT) ? 4'b1111 : 4'b0000) || fall !== 4'b0000 || changed !== (k == LAT)) begin
                n_fail++;
                $display("FAIL simul_rise E%0d actual rise=%b fall=%b chg=%b expected rise=%b fall=0000 chg=%b",
                         k, rise, fall, changed, ((k == LAT) ? 4'b1111 : 4'b0000), (k == LAT));
            end
        end
        din = 4'b0000;
        for (int k = 0; k <= LAT + 2; k++) begin
            step();
            n_checks++;
            if (fall !== ((k == LAT) ? 4'b1111 : 4'b0000) || rise !== 4'b0000 || changed !== (k == LAT)) begin
                n_fail++;
                $display("FAIL simul_fall E%0d actual fall=%b rise=%b chg=%b expected fall=%b rise=0000 chg=%b",
                         k, fall, rise, changed, ((k == LAT) ? 4'b1111 : 4'b0000), (k == LAT));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic [3:0] prev_ev;
        prev_ev = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 7) == 0) din[c] = ~din[c];
            end
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                @(negedge clk);
                rst_n = 1'b1;
                prev_ev = 4'b0000;
            end
            step();
            n_checks++;
            if (((rise | fall) & prev_ev) !== 4'b0000) begin
                n_fail++;
                $display("FAIL random_back_to_back i=%0d actual=%b expected=0000", i, (rise | fall) & prev_ev);
            end
            prev_ev = rise | fall;
        end
        tick = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_tick_gating();
        test_simultaneous();
        test_random();
        repeat (2) step();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_debounce_bank
`default_nettype wire
